chef_hit_handler: RTL and testbench
===================================

// Module: chef_hit_handler
// PURPOSE
//   Consumer of enemy contact reports: turns enemy_hurt (plus optional
//   proximity test) into chef death, respawn, lives and game-over control.
//   Sits between the enemy instances and the chef / top-level game logic.
//   Issues the enemy_reset pulse that clears the enemy's latched hurt flag.
// PARAMETERS
//   LIVES_INIT     3    lives loaded at reset and on restart (1..7)
//   DEATH_FRAMES   60   frames chef stays frozen after a hit (1..255)
//   INVULN_FRAMES  120  post-respawn frames during which hits are ignored (1..255)
//   HIT_DIST       8    proximity half-window in pixels (HIT_PROXIMITY_EN only)
// PORTS
//   frame_clk     in   1   frame-rate clock, all state on rising edge
//   Reset_n       in   1   asynchronous active-low reset
//   start         in   1   level; begins/restarts game from IDLE or GAMEOVER
//   enemy_hurt    in   1   enemy's latched chef-contact flag (level)
//   ChefX, ChefY  in   10  chef position, pixels
//   EnemyX,EnemyY in   10  enemy position, pixels
//   chef_freeze   out  1   chef movement inhibit
//   chef_respawn  out  1   one-frame pulse: chef returns to start position
//   enemy_reset   out  1   one-frame pulse, active high, to enemy Reset
//   lives         out  3   remaining lives
//   invuln        out  1   high while hits are ignored
//   game_over     out  1   high in GAMEOVER
// BEHAVIOUR
//   - All outputs registered (Moore); one-frame latency state -> output.
//   - Reset_n low (any time, async): state=IDLE, count=0, lives=LIVES_INIT,
//     chef_freeze=1, chef_respawn=0, enemy_reset=0, invuln=0, game_over=0.
//   - hit = enemy_hurt (| proximity when macro enabled); sampled only in PLAY.
//   - States / transitions:
//     IDLE:     freeze=1. start -> RESPAWN (lives untouched).
//     PLAY:     freeze=0. hit -> DYING, lives<=lives-1, count<=DEATH_FRAMES-1.
//     DYING:    freeze=1; count-- each frame. count==0 -> GAMEOVER if lives==0
//               else RESPAWN. Ignores hit and start.
//     RESPAWN:  exactly one frame: chef_respawn=1, enemy_reset=1, freeze=1;
//               next INVULN, count<=INVULN_FRAMES-1.
//     INVULN:   freeze=0, invuln=1; count--, hits ignored. count==0 -> PLAY.
//     GAMEOVER: freeze=1, game_over=1. start -> lives<=LIVES_INIT, RESPAWN.
//   - start ignored outside IDLE/GAMEOVER; start held high after RESPAWN
//     never re-triggers (it is not sampled in PLAY/INVULN).
//   - enemy_hurt still high on entry to PLAY (enemy not yet cleared) counts
//     as a hit; enemy_reset in RESPAWN guarantees it is low by PLAY.
//   - lives never wraps: decrement only in PLAY->DYING, lives>=1 there.
//   - count is 8-bit, decrements saturate at 0.
//   - Hit and INVULN expiry same frame: INVULN->PLAY first; hit sampled next.
// CONFIGURATION
//   HIT_PROXIMITY_EN defined: hit also asserted when |ChefX-EnemyX|<HIT_DIST
//     and |ChefY-EnemyY|<HIT_DIST (unsigned 10-bit abs-difference).
//   Undefined: hit = enemy_hurt only; EnemyX/EnemyY unused, HIT_DIST ignored.
// TESTING
//   1. Reset_n low mid-DYING -> IDLE, lives=3, freeze=1, game_over=0 at once.
//   2. IDLE, start 1 frame -> respawn+enemy_reset pulse 1 frame, invuln 120
//      frames, then PLAY with freeze=0.
//   3. PLAY, enemy_hurt=1 -> lives 3->2, freeze=1 for 60 frames, then
//      RESPAWN pulse; enemy_hurt held during INVULN -> lives stays 2.
//   4. Three hits from LIVES_INIT=3 -> lives=0, GAMEOVER after 60 frames,
//      game_over=1; start -> lives=3, RESPAWN.
//   5. HIT_PROXIMITY_EN, enemy_hurt=0, Chef(100,50) Enemy(105,53) -> hit;
//      Enemy(108,50) -> no hit; macro off, Enemy(100,50) -> no hit.
//   6. start held high throughout PLAY/INVULN -> no extra respawn pulses.

Source files
------------

// File: rtl/chef_hit_handler.sv
// chef_hit_handler: turns enemy contact reports into chef death, respawn,
// lives and game-over control. All outputs are registered (Moore).
//
// Optional feature macro: HIT_PROXIMITY_EN
//   When defined, a hit is also raised whenever the chef and the enemy are
//   within HIT_DIST pixels of each other on both axes. When undefined, a hit
//   is enemy_hurt alone, and EnemyX/EnemyY/HIT_DIST have no effect.
module chef_hit_handler #(
  parameter int LIVES_INIT    = 3,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int HIT_DIST      = 8
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       enemy_hurt,
  input  logic [9:0] ChefX,
  input  logic [9:0] ChefY,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  output logic       chef_freeze,
  output logic       chef_respawn,
  output logic       enemy_reset,
  output logic [2:0] lives,
  output logic       invuln,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_DYING    = 3'd2,
    ST_RESPAWN  = 3'd3,
    ST_INVULN   = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  typedef struct packed {
    logic freeze;
    logic respawn;
    logic ereset;
    logic inv;
    logic gover;
  } outs_t;

  localparam logic [2:0] LIVES_LOAD  = 3'(LIVES_INIT);
  localparam logic [7:0] DEATH_LOAD  = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] count;
  logic [7:0] count_nxt;
  logic [2:0] lives_nxt;
  outs_t      outs;
  logic       hit;

  // Output pattern belonging to each state; unknown encodings freeze the chef.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o = '{freeze: 1'b1, respawn: 1'b0, ereset: 1'b0, inv: 1'b0, gover: 1'b0};
    case (s)
      ST_IDLE:     o.freeze = 1'b1;
      ST_PLAY:     o.freeze = 1'b0;
      ST_DYING:    o.freeze = 1'b1;
      ST_RESPAWN: begin
        o.freeze  = 1'b1;
        o.respawn = 1'b1;
        o.ereset  = 1'b1;
      end
      ST_INVULN: begin
        o.freeze = 1'b0;
        o.inv    = 1'b1;
      end
      ST_GAMEOVER: begin
        o.freeze = 1'b1;
        o.gover  = 1'b1;
      end
      default:     o.freeze = 1'b1;
    endcase
    return o;
  endfunction

  // Frame counter decrement that holds at zero.
  function automatic logic [7:0] dec_sat(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

`ifdef HIT_PROXIMITY_EN
  // Unsigned absolute difference of two pixel coordinates.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic near;
  assign near = (abs_diff(ChefX, EnemyX) < 10'(HIT_DIST)) &&
                (abs_diff(ChefY, EnemyY) < 10'(HIT_DIST));
  assign hit  = enemy_hurt | near;
`else
  logic unused_pos;
  assign unused_pos = ^{ChefX, ChefY, EnemyX, EnemyY};
  assign hit        = enemy_hurt;
`endif

  // Next-state, frame counter and lives bookkeeping.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lives_nxt = lives;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RESPAWN;
        else       state_nxt = ST_IDLE;
      end
      ST_PLAY: begin
        if (hit) begin
          state_nxt = ST_DYING;
          count_nxt = DEATH_LOAD;
          lives_nxt = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
        end else begin
          state_nxt = ST_PLAY;
        end
      end
      ST_DYING: begin
        if (count == 8'd0) begin
          if (lives == 3'd0) state_nxt = ST_GAMEOVER;
          else               state_nxt = ST_RESPAWN;
        end else begin
          count_nxt = dec_sat(count);
        end
      end
      ST_RESPAWN: begin
        state_nxt = ST_INVULN;
        count_nxt = INVULN_LOAD;
      end
      ST_INVULN: begin
        if (count == 8'd0) state_nxt = ST_PLAY;
        else               count_nxt = dec_sat(count);
      end
      ST_GAMEOVER: begin
        if (start) begin
          state_nxt = ST_RESPAWN;
          lives_nxt = LIVES_LOAD;
        end else begin
          state_nxt = ST_GAMEOVER;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = 8'd0;
        lives_nxt = LIVES_LOAD;
      end
    endcase
  end

  // State register with outputs registered from the state being entered.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      count <= 8'd0;
      lives <= LIVES_LOAD;
      outs  <= decode(ST_IDLE);
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      lives <= lives_nxt;
      outs  <= decode(state_nxt);
    end
  end

  assign chef_freeze  = outs.freeze;
  assign chef_respawn = outs.respawn;
  assign enemy_reset  = outs.ereset;
  assign invuln       = outs.inv;
  assign game_over    = outs.gover;

endmodule

// File: tb/tb_chef_hit_handler.sv
// Self-checking bench for chef_hit_handler against a frame-level game model.
module tb_chef_hit_handler;

  localparam int LIVES_INIT    = 3;
  localparam int DEATH_FRAMES  = 60;
  localparam int INVULN_FRAMES = 120;
  localparam int HIT_DIST      = 8;

  localparam int P_IDLE = 0, P_PLAY = 1, P_DYING = 2, P_RESPAWN = 3, P_INVULN = 4, P_OVER = 5;

  logic       frame_clk;
  logic       Reset_n;
  logic       start;
  logic       enemy_hurt;
  logic [9:0] ChefX, ChefY, EnemyX, EnemyY;
  logic       chef_freeze, chef_respawn, enemy_reset, invuln, game_over;
  logic [2:0] lives;

  int checks;
  int failures;

  // Model: current phase, frames left in that phase, lives left.
  int m_phase;
  int m_left;
  int m_lives;

  chef_hit_handler #(
    .LIVES_INIT(LIVES_INIT), .DEATH_FRAMES(DEATH_FRAMES),
    .INVULN_FRAMES(INVULN_FRAMES), .HIT_DIST(HIT_DIST)
  ) dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .start(start), .enemy_hurt(enemy_hurt),
    .ChefX(ChefX), .ChefY(ChefY), .EnemyX(EnemyX), .EnemyY(EnemyY),
    .chef_freeze(chef_freeze), .chef_respawn(chef_respawn), .enemy_reset(enemy_reset),
    .lives(lives), .invuln(invuln), .game_over(game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic bit model_hit();
    bit h;
    h = enemy_hurt;
`ifdef HIT_PROXIMITY_EN
    begin
      int dx, dy;
      dx = int'(ChefX) - int'(EnemyX);
      dy = int'(ChefY) - int'(EnemyY);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx < HIT_DIST && dy < HIT_DIST) h = 1'b1;
    end
`endif
    return h;
  endfunction

  // Expected {freeze, respawn, enemy_reset, lives, invuln, game_over}.
  function automatic logic [7:0] model_out();
    logic fr, rs, inv, go;
    fr  = (m_phase == P_IDLE) || (m_phase == P_DYING) || (m_phase == P_RESPAWN) || (m_phase == P_OVER);
    rs  = (m_phase == P_RESPAWN);
    inv = (m_phase == P_INVULN);
    go  = (m_phase == P_OVER);
    return {fr, rs, rs, 3'(m_lives), inv, go};
  endfunction

  function automatic logic [7:0] dut_out();
    return {chef_freeze, chef_respawn, enemy_reset, lives, invuln, game_over};
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_left  = 0;
    m_lives = LIVES_INIT;
  endtask

  task automatic model_step();
    bit h;
    h = model_hit();
    case (m_phase)
      P_IDLE:    if (start) m_phase = P_RESPAWN;
      P_PLAY:    if (h) begin m_lives = m_lives - 1; m_phase = P_DYING; m_left = DEATH_FRAMES; end
      P_DYING: begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = (m_lives == 0) ? P_OVER : P_RESPAWN;
      end
      P_RESPAWN: begin m_phase = P_INVULN; m_left = INVULN_FRAMES; end
      P_INVULN: begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = P_PLAY;
      end
      P_OVER:    if (start) begin m_lives = LIVES_INIT; m_phase = P_RESPAWN; end
      default:   m_phase = P_IDLE;
    endcase
  endtask

  // Advance one frame with the given inputs; outputs are stable on return.
  task automatic tick(input bit s, input bit h);
    @(negedge frame_clk);
    start      = s;
    enemy_hurt = h;
    @(posedge frame_clk);
    model_step();
    #1;
  endtask

  task automatic async_reset_now();
    @(posedge frame_clk);
    #3;
    Reset_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b0; enemy_hurt = 1'b0;
    ChefX = 10'd300; ChefY = 10'd200; EnemyX = 10'd0; EnemyY = 10'd0;
    Reset_n = 1'b0;
    model_reset();
    #7;
    checks++;
    if (dut_out() !== 8'b1_0_0_011_0_0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", dut_out(), 8'b1_0_0_011_0_0);
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL idle_hold f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_start_respawn();
    int pulses;
    pulses = 0;
    tick(1'b1, 1'b0);
    checks++;
    if (dut_out() !== {1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL respawn_pulse got=%b exp=%b", dut_out(), {1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0});
    end
    for (int i = 0; i < INVULN_FRAMES + 3; i++) begin
      tick(1'b0, 1'b0);
      if (chef_respawn) pulses++;
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL invuln_seq f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    checks++;
    if (pulses != 0 || chef_freeze !== 1'b0 || invuln !== 1'b0) begin
      failures++;
      $display("FAIL play_entry pulses=%0d freeze=%b invuln=%b exp 0/0/0", pulses, chef_freeze, invuln);
    end
  endtask

  task automatic test_hit_death();
    for (int i = 0; i < 1 + DEATH_FRAMES + 1 + INVULN_FRAMES; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL hit_seq f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    tick(1'b0, 1'b0);
    checks++;
    if (lives !== 3'd2 || chef_freeze !== 1'b0) begin
      failures++;
      $display("FAIL lives_after_invuln lives=%0d freeze=%b exp 2/0", lives, chef_freeze);
    end
  endtask

  task automatic test_gameover();
    int n;
    n = 0;
    while (m_phase != P_OVER && n < 2000) begin
      tick(1'b0, 1'b1);
      n++;
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL to_gameover f=%0d got=%b exp=%b", n, dut_out(), model_out());
      end
    end
    checks++;
    if (game_over !== 1'b1 || lives !== 3'd0 || n >= 2000) begin
      failures++;
      $display("FAIL gameover_state go=%b lives=%0d frames=%0d exp 1/0", game_over, lives, n);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL gameover_hold f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    tick(1'b1, 1'b0);
    checks++;
    if (dut_out() !== {1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL restart got=%b exp=%b", dut_out(), {1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0});
    end
  endtask

  task automatic test_start_held();
    int pulses;
    pulses = 0;
    for (int i = 0; i < INVULN_FRAMES + 60; i++) begin
      tick(1'b1, 1'b0);
      if (chef_respawn) pulses++;
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL start_held f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL start_held_pulses got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_proximity();
    ChefX = 10'd100; ChefY = 10'd50; EnemyX = 10'd105; EnemyY = 10'd53;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL prox_near f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    // Recover to PLAY if the near case was a hit, then try the edge distance.
    for (int i = 0; i < 400 && m_phase != P_PLAY; i++) begin
      ChefX = 10'd400;
      tick(1'b0, 1'b0);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL prox_recover f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    ChefX = 10'd100; ChefY = 10'd50; EnemyX = 10'd108; EnemyY = 10'd50;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL prox_edge f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
    EnemyX = 10'd100;
    tick(1'b0, 1'b0);
    checks++;
    if (dut_out() !== model_out()) begin
      failures++;
      $display("FAIL prox_same got=%b exp=%b", dut_out(), model_out());
    end
  endtask

  task automatic test_reset_mid_dying();
    int n;
    n = 0;
    while (m_phase != P_PLAY && n < 1000) begin
      tick(1'b1, 1'b0);
      n++;
    end
    tick(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    checks++;
    if (chef_freeze !== 1'b1 || m_phase != P_DYING) begin
      failures++;
      $display("FAIL pre_reset_dying freeze=%b exp 1 (model phase %0d)", chef_freeze, m_phase);
    end
    async_reset_now();
    checks++;
    if (dut_out() !== model_out()) begin
      failures++;
      $display("FAIL reset_mid_dying got=%b exp=%b", dut_out(), model_out());
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      ChefX = 10'($urandom_range(0, 1023));
      ChefY = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) begin
        EnemyX = 10'(int'(ChefX) + $urandom_range(0, 20) - 10);
        EnemyY = 10'(int'(ChefY) + $urandom_range(0, 20) - 10);
      end else begin
        EnemyX = 10'($urandom_range(0, 1023));
        EnemyY = 10'($urandom_range(0, 1023));
      end
      if (i == 1500) begin
        async_reset_now();
        checks++;
        if (dut_out() !== model_out()) begin
          failures++;
          $display("FAIL rand_reset got=%b exp=%b", dut_out(), model_out());
        end
        release_reset();
      end
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0));
      checks++;
      if (dut_out() !== model_out()) begin
        failures++;
        $display("FAIL random f=%0d got=%b exp=%b", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_start_respawn();
    test_hit_death();
    test_gameover();
    test_start_held();
    test_proximity();
    test_reset_mid_dying();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
